demux4x16_buffered: RTL and testbench

- 1-to-4, 16-bit demultiplexer. It is the distributing counterpart of the 4x16 selector: one producer stream is steered to one of four consumer channels.
- Each output channel has a one-entry output register with a valid/ready handshake, so a stalled consumer blocks only traffic addressed to it.
- A broadcast mode delivers one word to all four channels atomically.
- It sits between the datapath result bus and the register-file/memory write ports.

---
 rtl/demux4x16_buffered_pkg.sv | 16 +
 rtl/demux4x16_buffered_out_slot.sv | 63 ++++++
 rtl/demux4x16_buffered.sv | 71 +++++++
 tb/tb_demux4x16_buffered.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demux4x16_buffered_pkg.sv
// Shared constants and the channel-select decode for the buffered 1-to-4 demultiplexer.
package demux4x16_buffered_pkg;

  localparam int NUM_CH         = 4;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int SEL_WIDTH_DEF  = 2;
  localparam int CNT_WIDTH_DEF  = 8;

  function automatic logic [NUM_CH-1:0] sel_to_mask(input logic [SEL_WIDTH_DEF-1:0] sel);
    logic [NUM_CH-1:0] mask;
    mask      = '0;
    mask[sel] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/demux4x16_buffered_out_slot.sv
// One output channel register: holds valid/data plus a delivered-word counter; loads 1 cycle after accept.
// free is high when empty or draining this cycle, so a stalled consumer only blocks its own slot.
module demux4x16_buffered_out_slot
  import demux4x16_buffered_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  ready,
  input  logic                  clr_cnt,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [CNT_WIDTH-1:0]  cnt,
  output logic                  free
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  hshake;

  assign hshake = valid_q & ready;
  assign free   = ~valid_q | ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    // A load in the same cycle as a drain keeps the slot full with the new word.
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (hshake) begin
      valid_d = 1'b0;
    end
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (hshake) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign cnt   = cnt_q;

endmodule

// File: rtl/demux4x16_buffered.sv
// Steers one producer stream to one of four registered channels (or all four on broadcast); 1-cycle latency.
// in_ready depends only on slot state and out_ready; broadcast waits until every slot is free.
module demux4x16_buffered
  import demux4x16_buffered_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SEL_WIDTH  = SEL_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [SEL_WIDTH-1:0]  in_sel,
  input  logic                  in_bcast,
  output logic [NUM_CH-1:0]     out_valid,
  input  logic [NUM_CH-1:0]     out_ready,
  output logic [DATA_WIDTH-1:0] out_data0,
  output logic [DATA_WIDTH-1:0] out_data1,
  output logic [DATA_WIDTH-1:0] out_data2,
  output logic [DATA_WIDTH-1:0] out_data3,
  output logic [CNT_WIDTH-1:0]  cnt0,
  output logic [CNT_WIDTH-1:0]  cnt1,
  output logic [CNT_WIDTH-1:0]  cnt2,
  output logic [CNT_WIDTH-1:0]  cnt3,
  input  logic                  clr_cnt
);

  logic [NUM_CH-1:0]     free;
  logic [NUM_CH-1:0]     target;
  logic [NUM_CH-1:0]     load;
  logic                  accept;
  logic [DATA_WIDTH-1:0] data_arr [NUM_CH];
  logic [CNT_WIDTH-1:0]  cnt_arr  [NUM_CH];

  assign target = in_bcast ? {NUM_CH{1'b1}} : sel_to_mask(in_sel);

  // Held in reset the slots look empty, so ready is forced low to keep the producer out.
  assign in_ready = rst_n & (in_bcast ? (&free) : free[in_sel]);
  assign accept   = in_valid & in_ready;
  assign load     = accept ? target : '0;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    demux4x16_buffered_out_slot #(
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[i]),
      .load_data (in_data),
      .ready     (out_ready[i]),
      .clr_cnt   (clr_cnt),
      .valid     (out_valid[i]),
      .data      (data_arr[i]),
      .cnt       (cnt_arr[i]),
      .free      (free[i])
    );
  end

  assign out_data0 = data_arr[0];
  assign out_data1 = data_arr[1];
  assign out_data2 = data_arr[2];
  assign out_data3 = data_arr[3];
  assign cnt0      = cnt_arr[0];
  assign cnt1      = cnt_arr[1];
  assign cnt2      = cnt_arr[2];
  assign cnt3      = cnt_arr[3];

endmodule

// File: tb/tb_demux4x16_buffered.sv
// Directed bench for demux4x16_buffered: reset, unicast, isolation, streaming, broadcast, counters.
module tb_demux4x16_buffered;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_sel;
  logic        in_bcast;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] out_data0, out_data1, out_data2, out_data3;
  logic [7:0]  cnt0, cnt1, cnt2, cnt3;
  logic        clr_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  demux4x16_buffered dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_bcast  (in_bcast),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .cnt0      (cnt0),
    .cnt1      (cnt1),
    .cnt2      (cnt2),
    .cnt3      (cnt3),
    .clr_cnt   (clr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'($urandom);
    in_data   = 16'($urandom);
    in_sel    = 2'($urandom);
    in_bcast  = 1'($urandom);
    out_ready = 4'($urandom);
    clr_cnt   = 1'($urandom);

    // Reset with random inputs
    repeat (3) tick();
    in_valid = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_data0", 32'(out_data0), 32'h0);
    check("rst_data1", 32'(out_data1), 32'h0);
    check("rst_data2", 32'(out_data2), 32'h0);
    check("rst_data3", 32'(out_data3), 32'h0);
    check("rst_cnts", {cnt3, cnt2, cnt1, cnt0}, 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h0);

    // First accept on the first edge after release
    tick();
    rst_n     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h1111;
    in_sel    = 2'd0;
    in_bcast  = 1'b0;
    out_ready = 4'b1111;
    clr_cnt   = 1'b0;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    check("rel_out_valid", 32'(out_valid), 32'h1);
    check("rel_data0", 32'(out_data0), 32'h1111);
    tick();
    check("rel_drain_valid", 32'(out_valid), 32'h0);
    check("rel_cnt0", 32'(cnt0), 32'h1);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("clr_cnt0", 32'(cnt0), 32'h0);

    // Unicast to channel 2
    in_valid = 1'b1;
    in_data  = 16'h1234;
    in_sel   = 2'd2;
    tick();
    in_valid = 1'b0;
    check("uni_out_valid", 32'(out_valid), 32'h4);
    check("uni_data2", 32'(out_data2), 32'h1234);
    check("uni_cnt2_pre", 32'(cnt2), 32'h0);
    tick();
    check("uni_cnt2", 32'(cnt2), 32'h1);
    check("uni_other_cnts", {cnt3, cnt1, cnt0}, 32'h0);
    check("uni_drained", 32'(out_valid), 32'h0);

    // Backpressure isolation: channel 1 stalled and full
    out_ready = 4'b1101;
    in_valid  = 1'b1;
    in_data   = 16'h5555;
    in_sel    = 2'd1;
    tick();
    check("bp_fill1", 32'(out_valid), 32'h2);
    in_data = 16'h6666;
    #1;
    check("bp_in_ready_sel1", 32'(in_ready), 32'h0);
    tick();
    check("bp_data1_held", 32'(out_data1), 32'h5555);
    check("bp_valid_held", 32'(out_valid), 32'h2);
    in_data = 16'hBEEF;
    in_sel  = 2'd3;
    #1;
    check("bp_in_ready_sel3", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    check("bp_data3", 32'(out_data3), 32'hBEEF);
    check("bp_valid_13", 32'(out_valid), 32'hA);
    check("bp_data1_still", 32'(out_data1), 32'h5555);
    tick();
    check("bp_drain3", 32'(out_valid), 32'h2);
    check("bp_cnt3", 32'(cnt3), 32'h1);

    // Streaming 8 words to channel 0 while channel 1 stays stalled
    in_sel = 2'd0;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data  = 16'hC000 + 16'(k);
      #1;
      check("str_in_ready", 32'(in_ready), 32'h1);
      tick();
      check("str_valid0", 32'(out_valid[0]), 32'h1);
      check("str_data0", 32'(out_data0), 32'hC000 + 32'(k));
    end
    in_valid = 1'b0;
    tick();
    check("str_cnt0", 32'(cnt0), 32'h8);
    check("str_valid_end", 32'(out_valid), 32'h2);

    // Broadcast blocked by a stalled full channel 2
    out_ready = 4'b1111;
    tick();
    check("bc_ch1_drain", 32'(out_valid), 32'h0);
    out_ready = 4'b1011;
    in_valid  = 1'b1;
    in_sel    = 2'd2;
    in_data   = 16'h2222;
    tick();
    check("bc_fill2", 32'(out_valid), 32'h4);
    in_bcast = 1'b1;
    in_data  = 16'hA5A5;
    in_sel   = 2'd0;
    #1;
    check("bc_in_ready_blocked", 32'(in_ready), 32'h0);
    tick();
    check("bc_no_load_valid", 32'(out_valid), 32'h4);
    check("bc_no_load_data2", 32'(out_data2), 32'h2222);
    check("bc_no_load_data0", 32'(out_data0), 32'hC007);
    out_ready = 4'b1111;
    #1;
    check("bc_in_ready_open", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    in_bcast = 1'b0;
    check("bc_valid_all", 32'(out_valid), 32'hF);
    check("bc_data0", 32'(out_data0), 32'hA5A5);
    check("bc_data1", 32'(out_data1), 32'hA5A5);
    check("bc_data2", 32'(out_data2), 32'hA5A5);
    check("bc_data3", 32'(out_data3), 32'hA5A5);
    check("bc_cnt2_drain_load", 32'(cnt2), 32'h2);
    tick();
    check("bc_drain_all", 32'(out_valid), 32'h0);

    // Counter wrap on channel 0
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("wrap_clr", {cnt3, cnt2, cnt1, cnt0}, 32'h0);
    in_valid = 1'b1;
    in_sel   = 2'd0;
    for (int k = 0; k < 256; k++) begin
      in_data = 16'(k);
      tick();
    end
    check("wrap_cnt0_255", 32'(cnt0), 32'hFF);
    in_valid = 1'b0;
    tick();
    check("wrap_cnt0_0", 32'(cnt0), 32'h0);
    check("wrap_cnt1", 32'(cnt1), 32'h0);

    // Clear wins over a same-cycle handshake
    in_valid = 1'b1;
    in_data  = 16'h0A0A;
    tick();
    tick();
    in_valid = 1'b0;
    check("clrhs_cnt0_pre", 32'(cnt0), 32'h1);
    check("clrhs_valid_pre", 32'(out_valid), 32'h1);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("clrhs_cnt0", 32'(cnt0), 32'h0);
    check("clrhs_valid", 32'(out_valid), 32'h0);

    // Asynchronous reset mid-operation discards a held word
    out_ready = 4'b0000;
    in_valid  = 1'b1;
    in_sel    = 2'd3;
    in_data   = 16'h7777;
    tick();
    in_valid = 1'b0;
    check("mid_held", 32'(out_data3), 32'h7777);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_data3", 32'(out_data3), 32'h0);
    check("mid_rst_in_ready", 32'(in_ready), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
